// File: rtl/system_ecc_pkg.sv
// Shared constants and helpers for the Hamming(12,8) + system parity decoder.
package system_ecc_pkg;

  localparam int unsigned N           = 13;
  localparam int unsigned K           = 8;
  localparam int unsigned HAMMING_N   = 12;
  localparam int unsigned SYS_PAR_IDX = 12;

  localparam logic [3:0] ERR_POS_NONE = 4'hF;

  // Hamming check bits sit at the power-of-two positions (1-based 1,2,4,8).
  localparam logic [3:0] PARITY_IDX [4] = '{4'd0, 4'd1, 4'd3, 4'd7};
  // Data bit d[i] lives at codeword index DATA_IDX[i].
  localparam logic [3:0] DATA_IDX   [8] = '{4'd2, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11};

  typedef enum logic [1:0] {
    ECC_CLEAN     = 2'd0,
    ECC_CORRECTED = 2'd1,
    ECC_UNCORR    = 2'd2
  } ecc_class_e;

  function automatic logic [K-1:0] extract_data(input logic [N-1:0] cw);
    logic [K-1:0] d;
    d = '0;
    for (int unsigned i = 0; i < K; i++) begin
      d[i] = cw[DATA_IDX[i]];
    end
    return d;
  endfunction

endpackage

// File: rtl/system_ecc_syndrome.sv
// Combinational SEC-DED logic: syndrome/overall parity of the incoming
// codeword, and classification/correction of the codeword held in stage 1.
module system_ecc_syndrome
  import system_ecc_pkg::*;
(
  input  logic [N-1:0] codeword_i,
  output logic [3:0]   syndrome_o,
  output logic         parity_o,
  input  logic [N-1:0] s1_codeword_i,
  input  logic [3:0]   s1_syndrome_i,
  input  logic         s1_parity_i,
  output logic [K-1:0] data_o,
  output logic         err_corrected_o,
  output logic         err_uncorrectable_o,
  output logic [3:0]   err_pos_o
);

  ecc_class_e   cls;
  logic [N-1:0] fixed_cw;

  // Syndrome bit i collects every Hamming bit whose 1-based position has bit i set.
  always_comb begin
    syndrome_o = '0;
    for (int unsigned j = 0; j < HAMMING_N; j++) begin
      syndrome_o = syndrome_o ^ ({4{codeword_i[j]}} & 4'(j + 1));
    end
    parity_o = ^codeword_i;
  end

  // Classify the stage-1 word and flip the located bit when correctable.
  always_comb begin
    cls       = ECC_CLEAN;
    fixed_cw  = s1_codeword_i;
    err_pos_o = ERR_POS_NONE;
    if (s1_syndrome_i == 4'd0) begin
      if (s1_parity_i) begin
        // Only the system parity bit is wrong; data is unaffected.
        cls       = ECC_CORRECTED;
        err_pos_o = 4'(SYS_PAR_IDX);
      end
    end else if (s1_parity_i && (s1_syndrome_i <= 4'(HAMMING_N))) begin
      cls = ECC_CORRECTED;
      for (int unsigned j = 0; j < HAMMING_N; j++) begin
        if (s1_syndrome_i == 4'(j + 1)) begin
          fixed_cw[j] = ~s1_codeword_i[j];
          err_pos_o   = 4'(j);
        end
      end
    end else begin
      cls = ECC_UNCORR;
    end
    data_o              = extract_data(fixed_cw);
    err_corrected_o     = (cls == ECC_CORRECTED);
    err_uncorrectable_o = (cls == ECC_UNCORR);
  end

endmodule

// File: rtl/system_ecc_stream_decoder.sv
// Two-stage streaming SEC-DED decoder with valid/ready handshake.
// Optional error counters are built only when SYSTEM_ECC_STATS_EN is defined.
module system_ecc_stream_decoder
  import system_ecc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [12:0]           codeword_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  err_corrected,
  output logic                  err_uncorrectable,
  output logic [3:0]            err_pos,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  corr_count,
  output logic [CNT_WIDTH-1:0]  uncorr_count
);

  logic                  advance;

  logic                  s1_valid_q, s1_valid_d;
  logic [N-1:0]          s1_cw_q, s1_cw_d;
  logic [3:0]            s1_syn_q, s1_syn_d;
  logic                  s1_par_q, s1_par_d;

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  corr_q, corr_d;
  logic                  uncorr_q, uncorr_d;
  logic [3:0]            pos_q, pos_d;

  logic [3:0]            syn_w;
  logic                  par_w;
  logic [K-1:0]          cls_data;
  logic                  cls_corr;
  logic                  cls_uncorr;
  logic [3:0]            cls_pos;

  system_ecc_syndrome u_syndrome (
    .codeword_i          (codeword_in),
    .syndrome_o          (syn_w),
    .parity_o            (par_w),
    .s1_codeword_i       (s1_cw_q),
    .s1_syndrome_i       (s1_syn_q),
    .s1_parity_i         (s1_par_q),
    .data_o              (cls_data),
    .err_corrected_o     (cls_corr),
    .err_uncorrectable_o (cls_uncorr),
    .err_pos_o           (cls_pos)
  );

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance;

  // Pipeline next-state: both stages move together only on advance; bubbles clear valid.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_cw_d     = s1_cw_q;
    s1_syn_d    = s1_syn_q;
    s1_par_d    = s1_par_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    corr_d      = corr_q;
    uncorr_d    = uncorr_q;
    pos_d       = pos_q;
    if (advance) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_cw_d  = codeword_in;
        s1_syn_d = syn_w;
        s1_par_d = par_w;
      end
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        data_d   = DATA_WIDTH'(cls_data);
        corr_d   = cls_corr;
        uncorr_d = cls_uncorr;
        pos_d    = cls_pos;
      end
    end
  end

  // Pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_cw_q     <= '0;
      s1_syn_q    <= '0;
      s1_par_q    <= 1'b0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      corr_q      <= 1'b0;
      uncorr_q    <= 1'b0;
      pos_q       <= ERR_POS_NONE;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_cw_q     <= s1_cw_d;
      s1_syn_q    <= s1_syn_d;
      s1_par_q    <= s1_par_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      corr_q      <= corr_d;
      uncorr_q    <= uncorr_d;
      pos_q       <= pos_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign data_out          = data_q;
  assign err_corrected     = corr_q;
  assign err_uncorrectable = uncorr_q;
  assign err_pos           = pos_q;

`ifdef SYSTEM_ECC_STATS_EN
  logic                 fire;
  logic [CNT_WIDTH-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_WIDTH-1:0] uncorr_cnt_q, uncorr_cnt_d;

  assign fire = out_valid_q && out_ready;

  // Saturating counters; clear wins over a same-cycle increment.
  always_comb begin
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (fire) begin
      if (corr_q && (corr_cnt_q != '1)) begin
        corr_cnt_d = corr_cnt_q + CNT_WIDTH'(1);
      end
      if (uncorr_q && (uncorr_cnt_q != '1)) begin
        uncorr_cnt_d = uncorr_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign corr_count   = corr_cnt_q;
  assign uncorr_count = uncorr_cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign corr_count     = '0;
  assign uncorr_count   = '0;
`endif

endmodule
